// File: rtl/msg_dispatch_if.sv
// Bundles msg_dispatch's FIFO inside port and the engine request/response channels.
// master = dispatcher side, slave = FIFO/engine side.
interface msg_dispatch_if #(
    parameter int W_MSG = 64,
    parameter int W_PAY = 40
);
    logic             in_msg_rdy;
    logic [W_MSG-1:0] in_msg;
    logic             in_msg_ack;
    logic             out_msg_rdy;
    logic [W_MSG-1:0] out_msg;
    logic             out_msg_ack;
    logic             req_valid;
    logic             req_ready;
    logic [7:0]       req_src;
    logic [7:0]       req_tag;
    logic [W_PAY-1:0] req_pay;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [7:0]       rsp_dst;
    logic [7:0]       rsp_tag;
    logic [W_PAY-1:0] rsp_data;

    modport master (
        input  in_msg_rdy, in_msg,
        output in_msg_ack,
        output out_msg_rdy, out_msg,
        input  out_msg_ack,
        output req_valid, req_src, req_tag, req_pay,
        input  req_ready,
        input  rsp_valid, rsp_dst, rsp_tag, rsp_data,
        output rsp_ready
    );

    modport slave (
        output in_msg_rdy, in_msg,
        input  in_msg_ack,
        input  out_msg_rdy, out_msg,
        output out_msg_ack,
        input  req_valid, req_src, req_tag, req_pay,
        output req_ready,
        output rsp_valid, rsp_dst, rsp_tag, rsp_data,
        input  rsp_ready
    );
endinterface

// File: rtl/msg_dispatch.sv
// Message dispatcher: pops inbound FIFO messages, routes EVAL to the engine, answers PING
// locally, drops the rest, and frames replies back into the FIFO. Statistics: MSG_DISPATCH_STATS_EN.
module msg_dispatch #(
    parameter int W_MSG = 64,
    parameter int W_PAY = 40
) (
    input  logic          clk,
    input  logic          rst_n,
    msg_dispatch_if.master bus,
    output logic [15:0]   rx_cnt,
    output logic [15:0]   tx_cnt,
    output logic [15:0]   drop_cnt
);
    localparam logic [7:0] OP_EVAL  = 8'h01;
    localparam logic [7:0] OP_PING  = 8'h02;
    localparam logic [7:0] RPL_EVAL = 8'h81;
    localparam logic [7:0] RPL_PING = 8'h82;

    typedef enum logic [1:0] {IN_IDLE, IN_ACK, IN_DISPATCH} in_state_t;
    typedef enum logic {OUT_IDLE, OUT_SEND} out_state_t;

    in_state_t        in_state, in_next;
    out_state_t       out_state, out_next;
    logic [W_MSG-1:0] msg_q;
    logic [W_MSG-1:0] ping_msg;
    logic             ping_full;
    logic             ping_wr;
    logic             ping_pop;
    logic             rsp_take;
    logic [7:0]       op_q;

    assign op_q            = msg_q[W_MSG-1 -: 8];
    assign bus.req_src     = msg_q[W_MSG-9 -: 8];
    assign bus.req_tag     = msg_q[W_MSG-17 -: 8];
    assign bus.req_pay     = msg_q[W_PAY-1:0];
    assign bus.in_msg_ack  = (in_state == IN_ACK);
    assign bus.out_msg_rdy = (out_state == OUT_SEND);

    // The FIFO head is captured in IDLE only; ACK deliberately ignores in_msg_rdy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_state <= IN_IDLE;
            msg_q    <= '0;
        end else begin
            in_state <= in_next;
            if (in_state == IN_IDLE && bus.in_msg_rdy)
                msg_q <= bus.in_msg;
        end
    end

    always_comb begin
        in_next       = in_state;
        ping_wr       = 1'b0;
        bus.req_valid = 1'b0;
        case (in_state)
            IN_IDLE:     if (bus.in_msg_rdy) in_next = IN_ACK;
            IN_ACK:      in_next = IN_DISPATCH;
            IN_DISPATCH: begin
                case (op_q)
                    OP_EVAL: begin
                        bus.req_valid = 1'b1;
                        if (bus.req_ready) in_next = IN_IDLE;
                    end
                    OP_PING: begin
                        if (!ping_full) begin
                            ping_wr = 1'b1;
                            in_next = IN_IDLE;
                        end
                    end
                    default: in_next = IN_IDLE;
                endcase
            end
            default:     in_next = IN_IDLE;
        endcase
    end

    // Write needs an empty buffer and pop needs a full one, so they never coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ping_full <= 1'b0;
            ping_msg  <= '0;
        end else if (ping_wr) begin
            ping_full <= 1'b1;
            ping_msg  <= {RPL_PING, msg_q[W_MSG-9:0]};
        end else if (ping_pop) begin
            ping_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_state   <= OUT_IDLE;
            bus.out_msg <= '0;
        end else begin
            out_state <= out_next;
            if (ping_pop)
                bus.out_msg <= ping_msg;
            else if (rsp_take)
                bus.out_msg <= {RPL_EVAL, bus.rsp_dst, bus.rsp_tag, bus.rsp_data};
        end
    end

    // A pending ping reply always wins over an engine result.
    always_comb begin
        out_next      = out_state;
        ping_pop      = 1'b0;
        rsp_take      = 1'b0;
        bus.rsp_ready = 1'b0;
        case (out_state)
            OUT_IDLE: begin
                bus.rsp_ready = !ping_full;
                if (ping_full) begin
                    ping_pop = 1'b1;
                    out_next = OUT_SEND;
                end else if (bus.rsp_valid) begin
                    rsp_take = 1'b1;
                    out_next = OUT_SEND;
                end
            end
            OUT_SEND: if (bus.out_msg_ack) out_next = OUT_IDLE;
            default:  out_next = OUT_IDLE;
        endcase
    end

`ifdef MSG_DISPATCH_STATS_EN
    logic drop;
    assign drop = (in_state == IN_DISPATCH) && (op_q != OP_EVAL) && (op_q != OP_PING);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_cnt   <= '0;
            tx_cnt   <= '0;
            drop_cnt <= '0;
        end else begin
            if (bus.in_msg_ack && rx_cnt != '1)
                rx_cnt <= rx_cnt + 16'd1;
            if (out_state == OUT_SEND && bus.out_msg_ack && tx_cnt != '1)
                tx_cnt <= tx_cnt + 16'd1;
            if (drop && drop_cnt != '1)
                drop_cnt <= drop_cnt + 16'd1;
        end
    end
`else
    assign rx_cnt   = '0;
    assign tx_cnt   = '0;
    assign drop_cnt = '0;
`endif
endmodule

// File: tb/tb_msg_dispatch.sv
// Self-checking bench for msg_dispatch: directed test-plan scenarios, then randomized
// FIFO/engine traffic scored against a queue-based reference model.
module tb_msg_dispatch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] rx_cnt, tx_cnt, drop_cnt;

`ifdef MSG_DISPATCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    msg_dispatch_if #(.W_MSG(64), .W_PAY(40)) bus ();

    msg_dispatch #(.W_MSG(64), .W_PAY(40)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .rx_cnt   (rx_cnt),
        .tx_cnt   (tx_cnt),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int in_acks  = 0;
    bit auto_pop = 1'b1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock step for the directed phase; acts as a single-entry FIFO and engine.
    task automatic tick();
        logic take;
        @(negedge clk);
        take = bus.rsp_valid && bus.rsp_ready;
        @(posedge clk);
        #1;
        if (take) bus.rsp_valid = 1'b0;
        if (bus.in_msg_ack) begin
            in_acks++;
            if (auto_pop) bus.in_msg_rdy = 1'b0;
        end
    endtask

    task automatic wait_out(input string tag);
        int n = 0;
        while (!bus.out_msg_rdy && n < 20) begin
            tick();
            n++;
        end
        check(tag, 64'(bus.out_msg_rdy), 64'd1);
    endtask

    task automatic ack_out();
        bus.out_msg_ack = 1'b1;
        tick();
        bus.out_msg_ack = 1'b0;
    endtask

    function automatic logic [63:0] rand_msg();
        logic [7:0]  op;
        int unsigned r;
        r  = $urandom_range(0, 7);
        op = (r < 4) ? 8'h01 : (r < 6) ? 8'h02 : (r == 6) ? 8'($urandom) : 8'h33;
        return {op, 8'($urandom), 8'($urandom), 8'($urandom), 32'($urandom)};
    endfunction

    logic [63:0] in_q[$], exp_req[$], exp_ping[$], exp_eval[$], pend[$];

    initial begin
        logic [63:0] a_msg, m, e, s_out, p_out, s_req;
        logic [63:0] seq[4];
        logic        s_ack, s_treq, s_trsp, s_cap, p_ack, p_ordy, p_oack;
        int          base, changes, rdy_low, rv, ro, n, cyc, rx_m, tx_m, drop_m;

        bus.in_msg_rdy  = 1'b0;
        bus.in_msg      = '0;
        bus.out_msg_ack = 1'b0;
        bus.req_ready   = 1'b1;
        bus.rsp_valid   = 1'b0;
        bus.rsp_dst     = '0;
        bus.rsp_tag     = '0;
        bus.rsp_data    = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ack", 64'(bus.in_msg_ack), 64'd0);
        check("rst_out_rdy", 64'(bus.out_msg_rdy), 64'd0);
        check("rst_out_msg", bus.out_msg, 64'd0);
        check("rst_req_valid", 64'(bus.req_valid), 64'd0);
        check("rst_cnts", {16'd0, rx_cnt, tx_cnt, drop_cnt}, 64'd0);
        rst_n = 1'b1;

        // EVAL: ack pulse, then request with captured fields
        bus.in_msg     = 64'h01052A00000000FF;
        bus.in_msg_rdy = 1'b1;
        tick();
        check("eval_ack_hi", 64'(bus.in_msg_ack), 64'd1);
        check("eval_req_early", 64'(bus.req_valid), 64'd0);
        tick();
        check("eval_ack_lo", 64'(bus.in_msg_ack), 64'd0);
        check("eval_req_valid", 64'(bus.req_valid), 64'd1);
        check("eval_req_fields", {bus.req_src, bus.req_tag, bus.req_pay}, 64'h00_00_05_2A_00000000FF);
        tick();
        check("eval_req_done", 64'(bus.req_valid), 64'd0);
        check("eval_acks", 64'(in_acks), 64'd1);

        // PING answered locally
        bus.in_msg     = 64'h020711000000ABCD;
        bus.in_msg_rdy = 1'b1;
        wait_out("ping_rdy");
        check("ping_out_msg", bus.out_msg, 64'h820711000000ABCD);
        check("ping_rsp_ready", 64'(bus.rsp_ready), 64'd0);
        tick();
        ack_out();
        check("ping_rdy_drop", 64'(bus.out_msg_rdy), 64'd0);

        // Withheld ack, buffer fill, inbound stall, ping-before-eval priority
        bus.in_msg     = 64'h0201A10000000001;
        bus.in_msg_rdy = 1'b1;
        wait_out("hold_a_rdy");
        a_msg = bus.out_msg;
        check("hold_a_msg", a_msg, 64'h8201A10000000001);
        base           = in_acks;
        bus.in_msg     = 64'h0202B20000000002;
        bus.in_msg_rdy = 1'b1;
        repeat (5) tick();
        bus.in_msg     = 64'h0203C30000000003;
        bus.in_msg_rdy = 1'b1;
        repeat (5) tick();
        check("hold_bc_acked", 64'(in_acks - base), 64'd2);
        bus.in_msg     = 64'h0204D40000000004;
        bus.in_msg_rdy = 1'b1;
        bus.rsp_dst    = 8'h09;
        bus.rsp_tag    = 8'h33;
        bus.rsp_data   = 40'h12345ABCDE;
        bus.rsp_valid  = 1'b1;
        base = in_acks; changes = 0; rdy_low = 0; rv = 0;
        repeat (20) begin
            tick();
            if (bus.out_msg !== a_msg) changes++;
            if (!bus.out_msg_rdy) rdy_low++;
            if (bus.rsp_ready) rv++;
        end
        check("hold_msg_stable", 64'(changes), 64'd0);
        check("hold_rdy_stable", 64'(rdy_low), 64'd0);
        check("stall_no_ack", 64'(in_acks - base), 64'd0);
        check("rsp_ready_blocked", 64'(rv), 64'd0);
        ack_out();
        seq[0] = 64'h8202B20000000002;
        seq[1] = 64'h8203C30000000003;
        seq[2] = 64'h8204D40000000004;
        seq[3] = 64'h81093312345ABCDE;
        for (int i = 0; i < 4; i++) begin
            wait_out($sformatf("prio%0d_rdy", i));
            check($sformatf("prio%0d_msg", i), bus.out_msg, seq[i]);
            tick();
            ack_out();
        end
        check("prio_d_acked", 64'(in_acks - base), 64'd1);
        check("prio_rsp_taken", 64'(bus.rsp_valid), 64'd0);
        check("prio_rdy_drop", 64'(bus.out_msg_rdy), 64'd0);

        // Unknown opcode dropped
        bus.in_msg     = 64'h3301020000000000;
        bus.in_msg_rdy = 1'b1;
        base = in_acks; rv = 0; ro = 0;
        repeat (8) begin
            tick();
            if (bus.req_valid) rv++;
            if (bus.out_msg_rdy) ro++;
        end
        check("drop_acks", 64'(in_acks - base), 64'd1);
        check("drop_no_req", 64'(rv), 64'd0);
        check("drop_no_out", 64'(ro), 64'd0);
        check("drop_cnt", 64'(drop_cnt), STATS ? 64'd1 : 64'd0);
        check("rx_cnt_dir", 64'(rx_cnt), STATS ? 64'd7 : 64'd0);
        check("tx_cnt_dir", 64'(tx_cnt), STATS ? 64'd6 : 64'd0);

        // Reset with inbound in ACK and outbound in SEND
        bus.in_msg     = 64'h020A0B0000000055;
        bus.in_msg_rdy = 1'b1;
        wait_out("rst_send_rdy");
        auto_pop       = 1'b0;
        bus.in_msg     = 64'h010C0D0000001234;
        bus.in_msg_rdy = 1'b1;
        n = 0;
        while (!bus.in_msg_ack && n < 20) begin
            tick();
            n++;
        end
        check("rst_pre_ack", 64'(bus.in_msg_ack), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_ack", 64'(bus.in_msg_ack), 64'd0);
        check("rst_async_rdy", 64'(bus.out_msg_rdy), 64'd0);
        check("rst_async_msg", bus.out_msg, 64'd0);
        check("rst_async_req", 64'(bus.req_valid), 64'd0);
        check("rst_async_cnts", {16'd0, rx_cnt, tx_cnt, drop_cnt}, 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        n = 0;
        while (!bus.in_msg_ack && n < 20) begin
            tick();
            n++;
        end
        check("rst_repop_ack", 64'(bus.in_msg_ack), 64'd1);
        bus.in_msg_rdy = 1'b0;
        tick();
        check("rst_repop_req", 64'(bus.req_valid), 64'd1);
        check("rst_repop_fields", {bus.req_src, bus.req_tag, bus.req_pay}, 64'h00_00_0C_0D_0000001234);
        auto_pop = 1'b1;
        ro = 0;
        repeat (5) begin
            tick();
            if (bus.out_msg_rdy) ro++;
        end
        check("rst_no_stale_out", 64'(ro), 64'd0);

        // Clean reset, then randomized traffic against the reference model
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        rx_m = 0; tx_m = 0; drop_m = 0; cyc = 0;
        p_ack = 1'b0; p_ordy = 1'b0; p_oack = 1'b0; p_out = '0;
        bus.in_msg_rdy = 1'b0;
        bus.rsp_valid  = 1'b0;
        while (cyc < 6000 && (cyc < 2500 || in_q.size() != 0 || exp_req.size() != 0 ||
               pend.size() != 0 || exp_ping.size() != 0 || exp_eval.size() != 0)) begin
            @(negedge clk);
            s_ack  = bus.in_msg_ack;
            s_treq = bus.req_valid && bus.req_ready;
            s_trsp = bus.rsp_valid && bus.rsp_ready;
            s_cap  = bus.out_msg_rdy && bus.out_msg_ack;
            s_out  = bus.out_msg;
            s_req  = {8'h01, bus.req_src, bus.req_tag, bus.req_pay};
            if (p_ack) check("ack_consec", 64'(s_ack), 64'd0);
            if (p_ordy && !p_oack) begin
                check("out_rdy_hold", 64'(bus.out_msg_rdy), 64'd1);
                check("out_msg_hold", s_out, p_out);
            end
            p_ack  = s_ack;
            p_ordy = bus.out_msg_rdy;
            p_oack = bus.out_msg_ack;
            p_out  = s_out;
            @(posedge clk);
            #1;
            if (s_ack) begin
                if (in_q.size() == 0) check("ack_spurious", 64'd1, 64'd0);
                else begin
                    m = in_q.pop_front();
                    rx_m++;
                    case (m[63:56])
                        8'h01:   exp_req.push_back(m);
                        8'h02:   exp_ping.push_back({8'h82, m[55:0]});
                        default: drop_m++;
                    endcase
                end
            end
            if (s_treq) begin
                if (exp_req.size() == 0) check("req_spurious", 64'd1, 64'd0);
                else begin
                    e = exp_req.pop_front();
                    check("req_msg", s_req, e);
                    pend.push_back({8'h81, s_req[55:40], s_req[39:0] ^ 40'hA55A5AA55A});
                end
            end
            if (s_trsp) exp_eval.push_back(pend.pop_front());
            if (s_cap) begin
                tx_m++;
                if (s_out[63:56] == 8'h82 && exp_ping.size() != 0)
                    check("ping_reply", s_out, exp_ping.pop_front());
                else if (s_out[63:56] == 8'h81 && exp_eval.size() != 0)
                    check("eval_reply", s_out, exp_eval.pop_front());
                else
                    check("out_unexpected", s_out, 64'd0);
            end
            if (cyc < 2500 && $urandom_range(0, 2) == 0) in_q.push_back(rand_msg());
            bus.in_msg_rdy = (in_q.size() != 0);
            bus.in_msg     = (in_q.size() != 0) ? in_q[0] : 64'd0;
            bus.req_ready  = 1'($urandom_range(0, 1));
            if (!bus.rsp_valid || s_trsp)
                bus.rsp_valid = (pend.size() != 0) && ($urandom_range(0, 1) == 1);
            if (pend.size() != 0) begin
                bus.rsp_dst  = pend[0][55:48];
                bus.rsp_tag  = pend[0][47:40];
                bus.rsp_data = pend[0][39:0];
            end
            bus.out_msg_ack = bus.out_msg_rdy && !bus.out_msg_ack && ($urandom_range(0, 2) == 0);
            cyc++;
        end
        check("drain_in", 64'(in_q.size()), 64'd0);
        check("drain_req", 64'(exp_req.size() + pend.size()), 64'd0);
        check("drain_out", 64'(exp_ping.size() + exp_eval.size()), 64'd0);
        check("traffic_seen", 64'(rx_m > 200), 64'd1);
        check("rx_cnt_rand", 64'(rx_cnt), STATS ? 64'(rx_m) : 64'd0);
        check("tx_cnt_rand", 64'(tx_cnt), STATS ? 64'(tx_m) : 64'd0);
        check("drop_cnt_rand", 64'(drop_cnt), STATS ? 64'(drop_m) : 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
